// File: rtl/servo_move_sequencer.sv
// Decodes UART command bytes and runs timed servo step sequences (face turns, scan-start pose).
// Holds one pending command while a sequence is running.
module servo_move_sequencer #(
  parameter int SETTLE_CYCLES = 50_000_000
) (
  input  logic       I_sys_clk,
  input  logic       I_reset,
  input  logic [7:0] I_rx_data,
  input  logic       I_rx_valid,
  output logic [7:0] o_servo_dir,
  output logic [3:0] o_servo_grip,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_cmd_error
);

  // state      | meaning
  // IDLE       | waiting for a command (pending slot has priority over rx)
  // ROT_OUT    | active servo rotated to +90deg
  // RELEASE    | active gripper opened
  // ROT_BACK   | active servo rotated home
  // REGRIP     | active gripper closed again; last face-turn step
  // SCAN_OPEN  | all grippers open, all servos home
  // SCAN_CLOSE | all grippers closed; last scan step
  typedef enum logic [2:0] {
    IDLE, ROT_OUT, RELEASE, ROT_BACK, REGRIP, SCAN_OPEN, SCAN_CLOSE
  } state_t;

  localparam int TW = $clog2(SETTLE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(SETTLE_CYCLES - 1);

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    cmd, cmd_next;          // {is_scan, servo index}
  logic [7:0]    dir, dir_next;
  logic [3:0]    grip, grip_next;
  logic          busy, busy_next;
  logic          done, done_next;
  logic          err, err_next;
  logic          pend_valid, pend_valid_next;
  logic [2:0]    pend_cmd, pend_cmd_next;

  logic          rx_known;
  logic [2:0]    rx_cmd;
  logic          rx_take;
  logic          start;
  logic [2:0]    start_cmd;

  always_comb begin
    rx_known = 1'b1;
    rx_cmd   = 3'b000;
    case (I_rx_data)
      8'h61:   rx_cmd = 3'b000;
      8'h63:   rx_cmd = 3'b001;
      8'h64:   rx_cmd = 3'b010;
      8'h65:   rx_cmd = 3'b011;
      8'h62:   rx_cmd = 3'b100;
      default: rx_known = 1'b0;
    endcase
  end

  assign rx_take = I_rx_valid && rx_known;

  always_comb begin
    state_next      = state;
    timer_next      = timer;
    cmd_next        = cmd;
    dir_next        = dir;
    grip_next       = grip;
    busy_next       = busy;
    done_next       = 1'b0;
    err_next        = I_rx_valid && !rx_known;
    pend_valid_next = pend_valid;
    pend_cmd_next   = pend_cmd;
    start           = 1'b0;
    start_cmd       = cmd;

    if (state == IDLE) begin
      if (pend_valid) begin
        // pending command starts; a simultaneous new byte takes the freed slot
        start           = 1'b1;
        start_cmd       = pend_cmd;
        pend_valid_next = rx_take;
        if (rx_take) pend_cmd_next = rx_cmd;
      end else if (rx_take) begin
        start     = 1'b1;
        start_cmd = rx_cmd;
      end
    end else begin
      timer_next = (timer == T_LAST) ? '0 : timer + TW'(1);
      if (rx_take) begin
        if (pend_valid) begin
          err_next = 1'b1;
        end else begin
          pend_valid_next = 1'b1;
          pend_cmd_next   = rx_cmd;
        end
      end
      if (timer == T_LAST) begin
        case (state)
          ROT_OUT: begin
            state_next          = RELEASE;
            grip_next[cmd[1:0]] = 1'b0;
          end
          RELEASE: begin
            state_next                      = ROT_BACK;
            dir_next[{cmd[1:0], 1'b0} +: 2] = 2'b00;
          end
          ROT_BACK: begin
            state_next          = REGRIP;
            grip_next[cmd[1:0]] = 1'b1;
          end
          SCAN_OPEN: begin
            state_next = SCAN_CLOSE;
            grip_next  = 4'hF;
          end
          default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        endcase
      end
    end

    if (start) begin
      busy_next  = 1'b1;
      timer_next = '0;
      cmd_next   = start_cmd;
      if (start_cmd[2]) begin
        state_next = SCAN_OPEN;
        grip_next  = 4'h0;
        dir_next   = 8'h00;
      end else begin
        state_next                            = ROT_OUT;
        dir_next[{start_cmd[1:0], 1'b0} +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_reset) begin
      state      <= IDLE;
      timer      <= '0;
      cmd        <= 3'b000;
      dir        <= 8'h00;
      grip       <= 4'hF;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pend_valid <= 1'b0;
      pend_cmd   <= 3'b000;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      cmd        <= cmd_next;
      dir        <= dir_next;
      grip       <= grip_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
      pend_valid <= pend_valid_next;
      pend_cmd   <= pend_cmd_next;
    end
  end

  assign o_servo_dir  = dir;
  assign o_servo_grip = grip;
  assign o_busy       = busy;
  assign o_done       = done;
  assign o_cmd_error  = err;

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Directed bench for servo_move_sequencer with SETTLE_CYCLES=8: checkpoint table plus
// hand-written sequences for busy length and the full-slot handoff at completion.
module tb_servo_move_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       vld = 1'b0;
  logic [7:0] dir;
  logic [3:0] grip;
  logic       busy, done, err;

  int tests = 0;
  int fails = 0;

  servo_move_sequencer #(.SETTLE_CYCLES(8)) dut (
    .I_sys_clk   (clk),
    .I_reset     (rst),
    .I_rx_data   (data),
    .I_rx_valid  (vld),
    .o_servo_dir (dir),
    .o_servo_grip(grip),
    .o_busy      (busy),
    .o_done      (done),
    .o_cmd_error (err)
  );

  always #5 clk = ~clk;

  // idle: quiet edges before the row's edge; outputs are checked right after the row's edge
  typedef struct {
    int         idle;
    logic       r;
    logic       v;
    logic [7:0] d;
    logic [7:0] e_dir;
    logic [3:0] e_grip;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int idle, input logic r, input logic v, input logic [7:0] d,
                     input logic [7:0] e_dir, input logic [3:0] e_grip,
                     input logic e_busy, input logic e_done, input logic e_err);
    vec_t x;
    x.idle = idle; x.r = r; x.v = v; x.d = d;
    x.e_dir = e_dir; x.e_grip = e_grip; x.e_busy = e_busy; x.e_done = e_done; x.e_err = e_err;
    tbl.push_back(x);
  endtask

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; vld = v; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int n_done;
    int n_err;
    bit saw_open;

    // reset
    add(0, 1, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    // face turn servo1
    add(0, 0, 1, 8'h61, 8'h01, 4'hF, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h01, 4'hF, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h01, 4'hE, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hE, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h00, 4'hE, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    // scan-start
    add(0, 0, 1, 8'h62, 8'h00, 4'h0, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h00, 4'h0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    // unknown bytes in IDLE
    add(0, 0, 1, 8'h7A, 8'h00, 4'hF, 0, 0, 1);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h00, 4'hF, 0, 0, 1);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    // back-to-back: servo2 runs, servo3 pending, servo4 dropped
    add(0, 0, 1, 8'h63, 8'h04, 4'hF, 1, 0, 0);
    add(0, 0, 1, 8'h64, 8'h04, 4'hF, 1, 0, 0);
    add(0, 0, 1, 8'h65, 8'h04, 4'hF, 1, 0, 1);
    add(0, 0, 0, 8'h00, 8'h04, 4'hF, 1, 0, 0);
    add(4, 0, 0, 8'h00, 8'h04, 4'hD, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hD, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hF, 0, 1, 0);
    add(0, 0, 0, 8'h00, 8'h10, 4'hF, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h10, 4'hB, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hB, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hF, 0, 1, 0);
    add(1, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    // reset during RELEASE with a pending scan
    add(0, 0, 1, 8'h61, 8'h01, 4'hF, 1, 0, 0);
    add(0, 0, 1, 8'h62, 8'h01, 4'hF, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h01, 4'hE, 1, 0, 0);
    add(0, 1, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    add(9, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);
    add(0, 0, 1, 8'h62, 8'h00, 4'h0, 1, 0, 0);
    add(6, 0, 0, 8'h00, 8'h00, 4'h0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0);
    add(7, 0, 0, 8'h00, 8'h00, 4'hF, 0, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].idle; k++) tick(1'b0, 1'b0, 8'h00);
      tick(tbl[i].r, tbl[i].v, tbl[i].d);
      check($sformatf("row%0d", i), int'({dir, grip, busy, done, err}),
            int'({tbl[i].e_dir, tbl[i].e_grip, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err}));
    end

    // scan busy length
    tick(1'b0, 1'b1, 8'h62);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick(1'b0, 1'b0, 8'h00);
    end
    check("scan_busy_cycles", n, 16);
    check("scan_done_at_end", int'(done), 1);
    tick(1'b0, 1'b0, 8'h00);

    // byte arrives at the first IDLE edge with the slot full
    tick(1'b0, 1'b1, 8'h63);
    tick(1'b0, 1'b1, 8'h64);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      n++;
      tick(1'b0, 1'b0, 8'h00);
    end
    check("handoff_first_done_timeout", int'(n < 100), 1);
    tick(1'b0, 1'b1, 8'h62);
    check("handoff_start", int'({dir, busy, err}), int'({8'h10, 1'b1, 1'b0}));
    n_done = 0;
    n_err = 0;
    saw_open = 1'b0;
    for (int c = 0; c < 120; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (grip === 4'h0) saw_open = 1'b1;
    end
    check("handoff_done_pulses", n_done, 2);
    check("handoff_errors", n_err, 0);
    check("handoff_scan_ran", int'(saw_open), 1);
    check("handoff_final", int'({dir, grip, busy}), int'({8'h00, 4'hF, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
